if_fetch: RTL and testbench

Fetch-stage controller for the uRISC pipeline, directly upstream of the instruction memory. Owns the program counter, drives the memory's address/enable/write port, and captures the returned 16-bit big-endian instruction into the IF/ID pipeline register. It handles:

- stalls from decode;
- redirects from branch resolution;
- HALT detection;
- unaligned-fetch errors reported by the memory.

---
 rtl/if_fetch.sv | 71 +++++++
 tb/tb_if_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: uRISC fetch stage. Owns the PC, reads instruction memory and fills the IF/ID register,
// stopping on HALT or an unaligned-fetch error until a redirect restarts it.
module if_fetch #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] imem_addr,
   output logic        imem_enable,
   output logic        imem_wr,
   output logic [15:0] imem_data_in,
   input  logic [15:0] imem_rdata,
   input  logic        imem_err,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic [15:0] pc_plus2,
   output logic        instr_valid,
   output logic        halted,
   output logic        fetch_err,
   output logic [15:0] err_pc
);
   typedef enum logic [1:0] {RUN, HALT, ERR} state_e;
   state_e      state_q;
   logic [15:0] pc_q, instr_q, instr_pc_q, pc_plus2_q, err_pc_q;
   logic        valid_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         pc_plus2_q <= '0;
         valid_q    <= 1'b0;
         err_pc_q   <= '0;
      end else if (redirect) begin
         // a redirect squashes everything, including a speculative HALT or fault
         pc_q    <= redirect_pc;
         valid_q <= 1'b0;
         state_q <= RUN;
      end else if (state_q == RUN) begin
         if (!stall) begin
            if (imem_err) begin
               state_q  <= ERR;
               err_pc_q <= pc_q;
               valid_q  <= 1'b0;
            end else begin
               instr_q    <= imem_rdata;
               instr_pc_q <= pc_q;
               pc_plus2_q <= pc_q + 16'd2;
               valid_q    <= 1'b1;
               if (imem_rdata[15:11] == HALT_OPCODE) state_q <= HALT;
               else pc_q <= pc_q + 16'd2;
            end
         end
      end else if (!stall) valid_q <= 1'b0;
   assign imem_addr    = pc_q;
   assign imem_enable  = state_q == RUN;
   assign imem_wr      = 1'b0;
   assign imem_data_in = 16'h0000;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign pc_plus2     = pc_plus2_q;
   assign instr_valid  = valid_q;
   assign halted       = state_q == HALT;
   assign fetch_err    = state_q == ERR;
   assign err_pc       = err_pc_q;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for if_fetch; a behavioural fetch model predicts every cycle's outputs
// and a negedge monitor compares them, alongside directed checks of the documented scenarios.
module tb_if_fetch;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic [15:0] imem_addr, imem_data_in, imem_rdata, instr, instr_pc, pc_plus2, err_pc;
   logic        imem_enable, imem_wr, imem_err, instr_valid, halted, fetch_err;
   logic [15:0] w_addr, w_din, w_rdata, w_instr, w_ipc, w_p2, w_epc;
   logic        w_en, w_wr, w_err, w_valid, w_halted, w_ferr;
   logic [15:0] mem [0:65535];
   always #5 clk = ~clk;
   assign imem_rdata = mem[imem_addr];
   assign imem_err   = imem_addr[0];
   assign w_rdata    = mem[w_addr];
   assign w_err      = w_addr[0];
   if_fetch #(.RESET_PC(16'h0000), .HALT_OPCODE(5'b00000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_enable(imem_enable), .imem_wr(imem_wr), .imem_data_in(imem_data_in),
      .imem_rdata(imem_rdata), .imem_err(imem_err), .instr(instr), .instr_pc(instr_pc),
      .pc_plus2(pc_plus2), .instr_valid(instr_valid), .halted(halted), .fetch_err(fetch_err), .err_pc(err_pc)
   );
   if_fetch #(.RESET_PC(16'hFFFE), .HALT_OPCODE(5'b00000)) dut_wrap (
      .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
      .imem_addr(w_addr), .imem_enable(w_en), .imem_wr(w_wr), .imem_data_in(w_din),
      .imem_rdata(w_rdata), .imem_err(w_err), .instr(w_instr), .instr_pc(w_ipc),
      .pc_plus2(w_p2), .instr_valid(w_valid), .halted(w_halted), .fetch_err(w_ferr), .err_pc(w_epc)
   );
   typedef struct packed {
      logic [15:0] addr; logic en, wr; logic [15:0] din, ins, ipc, p2;
      logic valid, hlt, ferr; logic [15:0] epc;
   } obs_t;
   obs_t exp_q[$];
   obs_t act;
   assign act = {imem_addr, imem_enable, imem_wr, imem_data_in, instr, instr_pc, pc_plus2,
                 instr_valid, halted, fetch_err, err_pc};
   int checks = 0, fails = 0;
   logic [15:0] m_pc, m_instr, m_ipc, m_p2, m_epc;
   logic        m_valid, m_halt, m_err;
   function automatic obs_t model_obs();
      return {m_pc, !(m_halt || m_err), 1'b0, 16'h0000, m_instr, m_ipc, m_p2, m_valid, m_halt, m_err, m_epc};
   endfunction
   task automatic model_reset();
      m_pc = 16'h0000; m_instr = '0; m_ipc = '0; m_p2 = '0; m_epc = '0;
      m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0;
   endtask
   task automatic model_step(input logic s, input logic r, input logic [15:0] rp);
      logic [15:0] w;
      if (r) begin
         m_pc = rp; m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0;
      end else if (m_halt || m_err) begin
         if (!s) m_valid = 1'b0;
      end else if (!s) begin
         if (m_pc[0]) begin
            m_err = 1'b1; m_epc = m_pc; m_valid = 1'b0;
         end else begin
            w = mem[m_pc];
            m_instr = w; m_ipc = m_pc; m_p2 = m_pc + 16'd2; m_valid = 1'b1;
            if (w[15:11] == 5'd0) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
         end
      end
   endtask
   always @(negedge clk)
      if (exp_q.size() > 0) begin
         obs_t e;
         e = exp_q.pop_front();
         checks++;
         if (act !== e) begin
            fails++;
            $display("FAIL scoreboard t=%0t got %h expected %h", $time, act, e);
         end
      end
   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s got %h expected %h", n, a, e);
      end
   endtask
   task automatic cycle(input logic s, input logic r, input logic [15:0] rp);
      stall = s; redirect = r; redirect_pc = rp;
      exp_q.push_back(model_obs());
      model_step(s, r, rp);
      @(posedge clk);
      #1;
   endtask
   task automatic check_reset(input string t);
      chk({t, "_addr"}, imem_addr, 16'h0000);
      chk({t, "_en"}, {15'd0, imem_enable}, 16'd1);
      chk({t, "_wr"}, {15'd0, imem_wr}, 16'd0);
      chk({t, "_din"}, imem_data_in, 16'h0000);
      chk({t, "_instr"}, instr, 16'h0000);
      chk({t, "_ipc"}, instr_pc, 16'h0000);
      chk({t, "_p2"}, pc_plus2, 16'h0000);
      chk({t, "_valid"}, {15'd0, instr_valid}, 16'd0);
      chk({t, "_halted"}, {15'd0, halted}, 16'd0);
      chk({t, "_ferr"}, {15'd0, fetch_err}, 16'd0);
      chk({t, "_epc"}, err_pc, 16'h0000);
   endtask
   initial begin
      logic [15:0] w;
      for (int i = 0; i < 65536; i++) begin
         w = 16'($urandom);
         if (w[15:11] == 5'd0) w[15] = 1'b1;
         mem[i] = w;
      end
      mem[0] = 16'h4001; mem[2] = 16'h4002; mem[4] = 16'h4003; mem[6] = 16'h0000;
      model_reset();
      @(posedge clk);
      #1;
      check_reset("reset");
      chk("wrap_reset_addr", w_addr, 16'hFFFE);
      rst = 1'b0;
      cycle(0, 0, 0);
      chk("seq0_instr", instr, 16'h4001);
      chk("seq0_ipc", instr_pc, 16'h0000);
      chk("seq0_p2", pc_plus2, 16'h0002);
      chk("seq0_valid", {15'd0, instr_valid}, 16'd1);
      chk("seq0_addr", imem_addr, 16'h0002);
      chk("wrap_ipc", w_ipc, 16'hFFFE);
      chk("wrap_p2", w_p2, 16'h0000);
      chk("wrap_addr", w_addr, 16'h0000);
      cycle(0, 0, 0);
      chk("seq1_instr", instr, 16'h4002);
      chk("seq1_ipc", instr_pc, 16'h0002);
      chk("seq1_addr", imem_addr, 16'h0004);
      repeat (2) begin
         cycle(1, 0, 0);
         chk("stall_addr", imem_addr, 16'h0004);
         chk("stall_instr", instr, 16'h4002);
         chk("stall_ipc", instr_pc, 16'h0002);
         chk("stall_valid", {15'd0, instr_valid}, 16'd1);
      end
      cycle(0, 0, 0);
      chk("unstall_instr", instr, 16'h4003);
      chk("unstall_addr", imem_addr, 16'h0006);
      cycle(0, 0, 0);
      chk("halt_instr", instr, 16'h0000);
      chk("halt_ipc", instr_pc, 16'h0006);
      chk("halt_valid", {15'd0, instr_valid}, 16'd1);
      chk("halt_flag", {15'd0, halted}, 16'd1);
      chk("halt_en", {15'd0, imem_enable}, 16'd0);
      chk("halt_addr", imem_addr, 16'h0006);
      cycle(0, 0, 0);
      chk("halt_valid_drop", {15'd0, instr_valid}, 16'd0);
      chk("halt_hold", {15'd0, halted}, 16'd1);
      cycle(1, 1, 16'h0010);
      chk("redir_addr", imem_addr, 16'h0010);
      chk("redir_valid", {15'd0, instr_valid}, 16'd0);
      chk("redir_halted", {15'd0, halted}, 16'd0);
      chk("redir_en", {15'd0, imem_enable}, 16'd1);
      cycle(0, 0, 0);
      chk("redir_ipc", instr_pc, 16'h0010);
      chk("redir_valid1", {15'd0, instr_valid}, 16'd1);
      cycle(0, 1, 16'h0101);
      chk("odd_addr", imem_addr, 16'h0101);
      cycle(0, 0, 0);
      chk("err_flag", {15'd0, fetch_err}, 16'd1);
      chk("err_pc", err_pc, 16'h0101);
      chk("err_en", {15'd0, imem_enable}, 16'd0);
      chk("err_valid", {15'd0, instr_valid}, 16'd0);
      repeat (3) begin
         cycle(0, 0, 0);
         chk("err_hold_addr", imem_addr, 16'h0101);
         chk("err_hold_flag", {15'd0, fetch_err}, 16'd1);
      end
      cycle(0, 1, 16'h0200);
      chk("err_clear", {15'd0, fetch_err}, 16'd0);
      chk("err_redir_addr", imem_addr, 16'h0200);
      cycle(0, 0, 0);
      chk("resume_ipc", instr_pc, 16'h0200);
      chk("resume_valid", {15'd0, instr_valid}, 16'd1);
      for (int i = 0; i < 12; i++) mem[16'h1000 + 16'($urandom_range(0, 255)) * 16'd2] = 16'h0000 | 16'($urandom_range(0, 2047));
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] rp;
         rp = 16'h1000 + 16'($urandom_range(0, 255)) * 16'd2;
         if ($urandom_range(0, 7) == 0) rp[0] = 1'b1;
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, rp);
      end
      #2;
      rst = 1'b1;
      #1;
      check_reset("async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (5) cycle(0, 0, 0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
